// File: rtl/irrigation_pkg.sv
// Shared types and default timing constants for the irrigation sequencer.
// Durations are in ticks of the 1 Hz pacing pulse.
package irrigation_pkg;

    localparam int TIME_W_DEFAULT        = 8;
    localparam int SPRINKLE_TIME_DEFAULT = 30;
    localparam int DRIP_TIME_DEFAULT     = 60;
    localparam int FILL_TIMEOUT_DEFAULT  = 120;
    localparam int SETTLE_TIME_DEFAULT   = 5;

    // Codes 6 and 7 are never entered; the sequencer maps them back to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_SPRINKLE = 3'd2,
        ST_DRIP     = 3'd3,
        ST_SETTLE   = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter pacing each timed phase; a load beats a coincident tick
// and the count saturates at zero.
module phase_timer #(
    parameter int TIME_W = irrigation_pkg::TIME_W_DEFAULT
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_load,
    input  logic [TIME_W-1:0] i_load_value,
    input  logic              i_tick,
    output logic [TIME_W-1:0] o_count,
    output logic              o_zero
);

    logic [TIME_W-1:0] r_count;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - TIME_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/irrigation_sequencer.sv
// Phase controller for refill, sprinkler/dripper runs and settle dead-time.
// Every actuator output is a registered decode of the next state, so at most one water path is ever open.
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int TIME_W        = TIME_W_DEFAULT,
    parameter int SPRINKLE_TIME = SPRINKLE_TIME_DEFAULT,
    parameter int DRIP_TIME     = DRIP_TIME_DEFAULT,
    parameter int FILL_TIMEOUT  = FILL_TIMEOUT_DEFAULT,
    parameter int SETTLE_TIME   = SETTLE_TIME_DEFAULT
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_tick,
    input  logic              i_irrigation_request,
    input  logic              i_splinker_mode,
    input  logic              i_conflicting_values,
    input  logic              i_low_water_level,
    input  logic              i_mid_water_level,
    input  logic              i_high_water_level,
    input  logic              i_fault_clear,
    output logic              o_splinker_bomb,
    output logic              o_dripper_valvule,
    output logic              o_water_supply_valvule,
    output logic              o_alarm,
    output logic [2:0]        o_state,
    output logic [TIME_W-1:0] o_remaining
);

    state_t            r_state;
    state_t            w_nextState;
    logic              r_splinkerBomb;
    logic              r_dripperValvule;
    logic              r_supplyValvule;
    logic              r_alarm;
    logic              w_load;
    logic [TIME_W-1:0] w_loadValue;
    logic [TIME_W-1:0] w_count;
    logic              w_zero;
    logic              w_expire;

    // The 1 -> 0 decrement is the clock on which a timed phase ends.
    assign w_expire = i_tick && (w_zero || (w_count == TIME_W'(1)));

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_conflicting_values) begin
                    w_nextState = ST_FAULT;
                end else if (!i_mid_water_level) begin
                    w_nextState = ST_FILL;
                end else if (i_irrigation_request && i_low_water_level) begin
                    w_nextState = i_splinker_mode ? ST_SPRINKLE : ST_DRIP;
                end
            end
            ST_FILL: begin
                if (i_conflicting_values) begin
                    w_nextState = ST_FAULT;
                end else if (i_high_water_level) begin
                    w_nextState = ST_IDLE;
                end else if (w_expire) begin
                    w_nextState = ST_FAULT;
                end
            end
            ST_SPRINKLE, ST_DRIP: begin
                if (i_conflicting_values) begin
                    w_nextState = ST_FAULT;
                end else if (!i_low_water_level) begin
                    w_nextState = ST_FILL;
                end else if (!i_irrigation_request || w_expire) begin
                    w_nextState = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (i_conflicting_values) begin
                    w_nextState = ST_FAULT;
                end else if (w_expire) begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (i_fault_clear && !i_conflicting_values) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Any phase change reloads the timer; untimed phases load zero.
    always_comb begin
        w_load = (w_nextState != r_state);
        case (w_nextState)
            ST_FILL:     w_loadValue = TIME_W'(FILL_TIMEOUT);
            ST_SPRINKLE: w_loadValue = TIME_W'(SPRINKLE_TIME);
            ST_DRIP:     w_loadValue = TIME_W'(DRIP_TIME);
            ST_SETTLE:   w_loadValue = TIME_W'(SETTLE_TIME);
            default:     w_loadValue = '0;
        endcase
    end

    phase_timer #(
        .TIME_W(TIME_W)
    ) u_phaseTimer (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_load      (w_load),
        .i_load_value(w_loadValue),
        .i_tick      (i_tick),
        .o_count     (w_count),
        .o_zero      (w_zero)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state          <= ST_IDLE;
            r_splinkerBomb   <= 1'b0;
            r_dripperValvule <= 1'b0;
            r_supplyValvule  <= 1'b0;
            r_alarm          <= 1'b0;
        end else begin
            r_state          <= w_nextState;
            r_splinkerBomb   <= (w_nextState == ST_SPRINKLE);
            r_dripperValvule <= (w_nextState == ST_DRIP);
            r_supplyValvule  <= (w_nextState == ST_FILL);
            r_alarm          <= (w_nextState == ST_FAULT);
        end
    end

    assign o_splinker_bomb        = r_splinkerBomb;
    assign o_dripper_valvule      = r_dripperValvule;
    assign o_water_supply_valvule = r_supplyValvule;
    assign o_alarm                = r_alarm;
    assign o_state                = r_state;
    assign o_remaining            = w_count;

endmodule
